// File: rtl/seq_alu_if.sv
// Issue/writeback bundle for seq_alu: op handshake in, result handshake out, busy status.
// The ALU side uses the slave modport; the issue/writeback side uses master.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic [3:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, r1, r2, control, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, r1, r2, control, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result/zero; iterative MUL/DIVU/REMU when SEQ_ALU_MULDIV_EN is defined.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/DIVU/REMU.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so at most one op in flight.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  seq_alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             accept;
  logic             is_md;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;

  assign bus.in_ready  = (state_q == IDLE) && !reset;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b0;
    unique case (bus.control)
      4'b0000: alu_res  = bus.r1 + bus.r2;
      4'b0001: alu_res  = bus.r1 & bus.r2;
      4'b0010: alu_res  = bus.r1 | bus.r2;
      4'b0011: alu_res  = bus.r1 << bus.r2[SHW-1:0];
      4'b0100: alu_res  = {{(WIDTH-1){1'b0}}, ($signed(bus.r1) < $signed(bus.r2))};
      4'b0101: alu_res  = bus.r1 >> bus.r2[SHW-1:0];
      4'b0110: alu_res  = bus.r1 - bus.r2;
      4'b0111: alu_res  = bus.r1 ^ bus.r2;
      4'b1000: alu_zero = (bus.r1 == bus.r2);
      4'b1001: alu_zero = (bus.r1 != bus.r2);
      default: alu_res  = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH + 1);

  // a: multiplicand / dividend-then-quotient; b: multiplier / divisor; acc: product / remainder
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   diff;
  logic             md_last;
  logic [WIDTH-1:0] md_res;

  assign is_md    = (bus.control == 4'b1010) || (bus.control == 4'b1011) ||
                    (bus.control == 4'b1100);
  assign bus.busy = (state_q == BUSY);
  assign md_last  = (cnt_q == CW'(WIDTH));
  assign md_res   = (op_q == 2'b11) ? a_q : acc_q;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    op_d   = op_q;
    rem_sh = {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
    diff   = {acc_q[WIDTH-1], rem_sh} - {1'b0, b_q};
    if (state_q == IDLE && accept && is_md) begin
      a_d   = bus.r1;
      b_d   = bus.r2;
      acc_d = '0;
      op_d  = bus.control[1:0];
    end else if (state_q == BUSY && !md_last) begin
      if (op_q == 2'b10) begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d = a_q << 1;
        b_d = b_q >> 1;
      end else if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh;
        a_d   = {a_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      op_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      op_q  <= op_d;
    end
  end
`else
  assign is_md    = 1'b0;
  assign bus.busy = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef SEQ_ALU_MULDIV_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_md) begin
            state_d = BUSY;
`ifdef SEQ_ALU_MULDIV_EN
            cnt_d   = '0;
`endif
          end else begin
            result_d = alu_res;
            zero_d   = alu_zero;
            state_d  = DONE;
          end
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      // WIDTH iterating cycles, then one cycle to register the finished value
      BUSY: begin
        if (md_last) begin
          result_d = md_res;
          zero_d   = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): stimulus pushes expectations, a negedge monitor pops and compares.
module tb_seq_alu;
  localparam int W = 32;

  logic clk;
  logic reset;
  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
  } exp_t;

  exp_t  sb_q[$];
  string sb_name[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: result 0x%h zero %0d with nothing expected", bus.result, bus.zero);
      end else begin
        exp_t  e;
        string nm;
        e  = sb_q.pop_front();
        nm = sb_name.pop_front();
        check({nm, "_result"}, bus.result, e.res);
        check({nm, "_zero"}, {{(W-1){1'b0}}, bus.zero}, {{(W-1){1'b0}}, e.z});
      end
    end
  end

  task automatic push_exp(input string name, input logic [W-1:0] er, input logic ez);
    exp_t e;
    e.res = er;
    e.z   = ez;
    sb_q.push_back(e);
    sb_name.push_back(name);
  endtask

  // Waits (bounded) until in_ready is seen at a negedge; returns 1 if it was.
  task automatic wait_ready(input string name, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept_timeout: in_ready 0, required 1 within 100 cycles", name);
    end
  endtask

  task automatic do_op(input string name, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                       input int lat);
    int n;
    bit ok, rdy_seen, busy_lost;
    bus.control  = c;
    bus.r1       = a;
    bus.r2       = b;
    bus.in_valid = 1'b1;
    wait_ready(name, ok);
    if (!ok) begin
      bus.in_valid = 1'b0;
      return;
    end
    push_exp(name, er, ez);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.r1       = ~a;
    bus.r2       = ~b;
    bus.control  = 4'b0000;
    n         = 0;
    rdy_seen  = 1'b0;
    busy_lost = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.out_valid) begin
        if (bus.in_ready) rdy_seen = 1'b1;
        if (!bus.busy) busy_lost = 1'b1;
      end
    end while (!bus.out_valid && n < 100);
    check({name, "_latency"}, n, lat);
    if (lat > 1) begin
      check({name, "_in_ready_low"}, {31'b0, rdy_seen}, 0);
      check({name, "_busy_high"}, {31'b0, busy_lost}, 0);
      check({name, "_busy_done"}, {31'b0, bus.busy}, 0);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef SEQ_ALU_MULDIV_EN
  localparam int MDL = W + 1;
`else
  localparam int MDL = 1;
`endif

  initial begin
    bit ok;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.control   = 4'b0000;
    bus.r1        = 32'd1;
    bus.r2        = 32'd2;
    bus.out_ready = 1'b1;

    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", {31'b0, bus.out_valid}, 0);
      check("rst_result", bus.result, 0);
      check("rst_zero", {31'b0, bus.zero}, 0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 0);
    end
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, bus.in_ready}, 1);
    @(posedge clk);
    #1;

    do_op("add",     4'b0000, 32'd5,        32'd7,        32'd12,       1'b0, 1);
    do_op("sub",     4'b0110, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1);
    do_op("slt_neg", 4'b0100, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
    do_op("slt_pos", 4'b0100, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1);
    do_op("and",     4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1);
    do_op("or",      4'b0010, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1);
    do_op("xor",     4'b0111, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1);
    do_op("sll",     4'b0011, 32'd1,        32'h21,       32'd2,        1'b0, 1);
    do_op("srl",     4'b0101, 32'h80000000, 32'h1F,       32'd1,        1'b0, 1);
    do_op("beq_eq",  4'b1000, 32'd9,        32'd9,        32'd0,        1'b1, 1);
    do_op("beq_ne",  4'b1000, 32'd9,        32'd8,        32'd0,        1'b0, 1);
    do_op("bne_eq",  4'b1001, 32'd9,        32'd9,        32'd0,        1'b0, 1);
    do_op("bne_ne",  4'b1001, 32'd9,        32'd8,        32'd0,        1'b1, 1);
    do_op("rsv_d",   4'b1101, 32'd9,        32'd9,        32'd0,        1'b0, 1);
    do_op("rsv_f",   4'b1111, 32'd3,        32'd3,        32'd0,        1'b0, 1);

`ifdef SEQ_ALU_MULDIV_EN
    do_op("mul_wrap", 4'b1010, 32'h00010000, 32'h00010000, 32'd0,        1'b0, MDL);
    do_op("mul_small",4'b1010, 32'd7,        32'd6,        32'd42,       1'b0, MDL);
    do_op("mul_ones", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, MDL);
    do_op("divu",     4'b1011, 32'd100,      32'd7,        32'd14,       1'b0, MDL);
    do_op("remu",     4'b1100, 32'd100,      32'd7,        32'd2,        1'b0, MDL);
    do_op("divu_z",   4'b1011, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, MDL);
    do_op("remu_z",   4'b1100, 32'd5,        32'd0,        32'd5,        1'b0, MDL);
`else
    do_op("rsv_mul",  4'b1010, 32'd7,        32'd6,        32'd0,        1'b0, MDL);
    do_op("rsv_divu", 4'b1011, 32'd100,      32'd7,        32'd0,        1'b0, MDL);
    do_op("rsv_remu", 4'b1100, 32'd100,      32'd7,        32'd0,        1'b0, MDL);
`endif

    // Backpressure: ADD 1+1 held in DONE while a second op waits at the input.
    bus.out_ready = 1'b0;
    bus.control   = 4'b0000;
    bus.r1        = 32'd1;
    bus.r2        = 32'd1;
    bus.in_valid  = 1'b1;
    wait_ready("bp_first", ok);
    push_exp("bp_first", 32'd2, 1'b0);
    @(posedge clk);
    #1;
    bus.r1 = 32'd3;
    bus.r2 = 32'd3;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", {31'b0, bus.out_valid}, 1);
      check("bp_result_held", bus.result, 32'd2);
      check("bp_in_ready", {31'b0, bus.in_ready}, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {31'b0, bus.in_ready}, 0);
    push_exp("bp_second", 32'd6, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_second_in_ready", {31'b0, bus.in_ready}, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_out_valid", {31'b0, bus.out_valid}, 1);
    @(posedge clk);
    #1;

    // Reset while a result waits in DONE discards it.
    bus.out_ready = 1'b0;
    bus.control   = 4'b0000;
    bus.r1        = 32'd8;
    bus.r2        = 32'd8;
    bus.in_valid  = 1'b1;
    wait_ready("rst_done", ok);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_done_out_valid", {31'b0, bus.out_valid}, 0);
    check("rst_done_result", bus.result, 0);

`ifdef SEQ_ALU_MULDIV_EN
    // Reset at iteration 10 of a DIVU: no output, back to IDLE.
    bus.control  = 4'b1011;
    bus.r1       = 32'd100;
    bus.r2       = 32'd7;
    bus.in_valid = 1'b1;
    wait_ready("rst_divu", ok);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_divu_out_valid", {31'b0, bus.out_valid}, 0);
    check("rst_divu_busy", {31'b0, bus.busy}, 0);
    check("rst_divu_in_ready", {31'b0, bus.in_ready}, 1);
    repeat (MDL + 2) @(negedge clk);
    check("rst_divu_stays_idle", {31'b0, bus.out_valid}, 0);
`endif
    @(posedge clk);
    #1;
    do_op("add_after_rst", 4'b0000, 32'd3, 32'd4, 32'd7, 1'b0, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
